// File: rtl/word_packer.sv
// Packs DATA_W-bit elements into LANES-wide words, first element in the MSB lane.
// Define WORD_PACKER_LAST_EN to let in_last close a word early.
module word_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  localparam int OUT_W = DATA_W * LANES,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  input  logic              out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid-side signals stay stable until that edge.

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             in_acc;
  logic             out_acc;
  logic             last_eff;
  logic             complete;
  logic [OUT_W-1:0] lane_val;
  logic [OUT_W-1:0] merged;

`ifdef WORD_PACKER_LAST_EN
  assign last_eff = in_last;
`else
  // Early closure is compiled out; in_last has no effect in this build.
  assign last_eff = in_last & 1'b0;
`endif

  assign in_ready = !clr && (!out_valid_q || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;
  assign complete = in_acc && ((cnt_q == CNT_W'(LANES - 1)) || last_eff);

  // Lane cnt counted from the MSB; lower lanes stay zero.
  assign lane_val = {in_data, {(OUT_W - DATA_W){1'b0}}} >> (DATA_W * cnt_q);
  assign merged   = acc_q | lane_val;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      cnt_d       = '0;
      acc_d       = '0;
      out_data_d  = '0;
      out_count_d = '0;
      out_last_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (out_acc) begin
        out_valid_d = 1'b0;
      end
      if (in_acc) begin
        if (complete) begin
          out_data_d  = merged;
          out_count_d = cnt_q + CNT_W'(1);
          out_last_d  = last_eff;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          acc_d       = '0;
        end else begin
          acc_d = merged;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer (DATA_W=8, LANES=4) with a queue scoreboard.
// Build with +define+WORD_PACKER_LAST_EN to exercise early word closure.
module tb_word_packer;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int OUT_W  = DATA_W * LANES;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int SB_W   = OUT_W + CNT_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_last;
  logic              out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];

  word_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [SB_W-1:0] pack(input logic [OUT_W-1:0] d,
                                           input int c, input logic l);
    return {d, CNT_W'(c), l};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: call at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    bit done = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: element 0x%0h not accepted in 50 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output accept pops one expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=0x%0h count=%0d last=%0b, expected no word",
                 out_data, out_count, out_last);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_data, out_count, out_last} !== e) begin
          errors++;
          $display("FAIL sb_word: got data=0x%0h count=%0d last=%0b expected data=0x%0h count=%0d last=%0b",
                   out_data, out_count, out_last,
                   e[SB_W-1 -: OUT_W], e[CNT_W:1], e[0]);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Full word, latency of exactly one cycle
    exp_q.push_back(pack(32'h11223344, 4, 1'b0));
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("full_not_early", 64'(out_valid), 64'd0);
    send(8'h44, 1'b0);
    chk("full_valid_next", 64'(out_valid), 64'd1);
    idle(1);
    chk("full_valid_one_cycle", 64'(out_valid), 64'd0);

`ifdef WORD_PACKER_LAST_EN
    // Early closure
    exp_q.push_back(pack(32'hAABB0000, 2, 1'b1));
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("last_valid", 64'(out_valid), 64'd1);
    idle(1);
    // in_last on first element, back-to-back with output accept
    exp_q.push_back(pack(32'hCC000000, 1, 1'b1));
    exp_q.push_back(pack(32'hDD000000, 1, 1'b1));
    send(8'hCC, 1'b1);
    send(8'hDD, 1'b1);
    chk("last_b2b_valid", 64'(out_valid), 64'd1);
    chk("last_b2b_data", 64'(out_data), 64'hDD000000);
    idle(1);
`else
    // in_last ignored
    exp_q.push_back(pack(32'hAABBCCDD, 4, 1'b0));
    send(8'hAA, 1'b1);
    chk("nolast_no_close", 64'(out_valid), 64'd0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    idle(1);
`endif

    // Backpressure hold, then stream
    out_ready = 1'b0;
    exp_q.push_back(pack(32'h01020304, 4, 1'b0));
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    in_data  = 8'h05;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_data", 64'(out_data), 64'h01020304);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    exp_q.push_back(pack(32'h05060708, 4, 1'b0));
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    chk("stream_valid", 64'(out_valid), 64'd1);
    idle(1);

    // Asynchronous reset mid-word
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(pack(32'h30313233, 4, 1'b0));
    send(8'h30, 1'b0);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    idle(1);

    // Synchronous clear while output is held
    out_ready = 1'b0;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_out_data",  64'(out_data),  64'd0);
    chk("clr_out_count", 64'(out_count), 64'd0);
    out_ready = 1'b1;
    exp_q.push_back(pack(32'h71727374, 4, 1'b0));
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    chk("clr_cnt_zero", 64'(out_valid), 64'd0);
    send(8'h74, 1'b0);
    idle(3);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 Parameter DATA_W, default 8, width of one input element in bits (>=1).
REQ-002 Parameter LANES, default 4, elements packed per output word (>=2).
REQ-003 Derived constants: OUT_W = DATA_W*LANES; CNT_W = $clog2(LANES+1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 clr  input  1  synchronous clear; discards the partial word and the held output word.
REQ-007 in_data  input  DATA_W  element to pack.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_last  input  1  element closes the current word early; qualified by in_valid.
REQ-010 in_ready  output  1  packer can accept an element this cycle.
REQ-011 out_data  output  OUT_W  packed word.
REQ-012 out_valid  output  1  out_data is valid and held.
REQ-013 out_count  output  CNT_W  number of real elements in out_data (1..LANES).
REQ-014 out_last  output  1  word was closed by in_last.
REQ-015 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-016 Input accept occurs when in_valid && in_ready at a rising edge; output accept occurs when out_valid && out_ready at a rising edge.
REQ-017 in_ready is combinational: in_ready = !clr && (!out_valid || out_ready).
REQ-018 The block keeps a partial-word accumulator (OUT_W bits) and a fill count cnt (0..LANES-1), separate from the output register.
REQ-019 Packing order: the first accepted element of a word occupies out_data[OUT_W-1 -: DATA_W]; each later element occupies the next lower lane.
REQ-020 A word completes on the accept that brings the element total to LANES, or, per the Configuration section, on an accept with in_last=1.
REQ-021 On completion, out_data is loaded with the accumulator plus the current element, with all unfilled lower lanes zero. In the same edge, out_count is loaded with the element total, out_last with in_last, and out_valid is set; cnt and the accumulator return to 0.
REQ-022 Latency: out_valid is high in the first cycle after the completing accept edge.
REQ-023 A non-completing accept stores the element in lane cnt (from MSB) and increments cnt.
REQ-024 out_data, out_count and out_last stay stable while out_valid=1 and out_ready=0.
REQ-025 An output accept with no completion in the same edge clears out_valid.
REQ-026 If an output accept and a completion occur on the same edge, the new word replaces the old one and out_valid stays 1, giving one word per LANES cycles with no bubbles.
REQ-027 If clr=1 at an edge: cnt=0, accumulator=0, out_valid=0, and out_data, out_count and out_last are zeroed. Any element presented that cycle is not accepted.
REQ-028 An in_last on the first element of a word produces out_count=1, with that element in the MSB lane and the remaining lanes zero.
REQ-029 While out_valid=1 and out_ready=0, no elements are accepted; the partial word is preserved unchanged.

Reset
REQ-030 When rst is asserted, it immediately forces cnt=0, accumulator=0, out_data=0, out_count=0, out_last=0 and out_valid=0, regardless of clk.
REQ-031 Reset asserted mid-word discards the partial word; the first accept after release starts a new word in the MSB lane.
REQ-032 in_ready follows REQ-017 during and after reset and is therefore 1 while clr=0.

Configuration
REQ-033 Macro WORD_PACKER_LAST_EN controls early word closure.
REQ-034 With WORD_PACKER_LAST_EN defined, in_last closes words early as in REQ-020, REQ-021 and REQ-028.
REQ-035 Without WORD_PACKER_LAST_EN, in_last is ignored, every word completes at LANES elements, out_last is constant 0, and out_count is always LANES when out_valid=1.

Verification (DATA_W=8, LANES=4, out_ready=1 unless stated)
REQ-036 Accept 0x11,0x22,0x33,0x44 on consecutive cycles -> out_data=0x11223344, out_count=4, out_last=0, out_valid high exactly one cycle after the 0x44 accept.
REQ-037 With the macro defined, accept 0xAA then 0xBB with in_last=1 -> out_data=0xAABB0000, out_count=2, out_last=1.
REQ-038 Complete 0x01020304 with out_ready=0 for 3 cycles -> in_ready=0 and out_data held for all 3 cycles; then stream 0x05..0x08 -> two words delivered with no gap cycle.
REQ-039 Accept 0x10,0x20, then pulse rst between clock edges, then accept 0x30..0x33 -> out_data=0x30313233.
REQ-040 Hold out_valid=1 with out_ready=0, then assert clr together with in_valid (0x55) -> out_valid=0 next cycle, 0x55 not accepted, cnt=0.
REQ-041 Without the macro, accept 0xAA with in_last=1, then 0xBB,0xCC,0xDD -> single word 0xAABBCCDD, out_last=0, out_count=4.
